// File: rtl/booth_seq_ctrl.sv
// -----------------------------------------------------------------------------
// booth_seq_ctrl
// Sequencing controller for a multi-cycle Booth multiplier (radix-2 or
// radix-4). It walks the datapath through load, recode/examine, add/subtract
// and shift steps for N iterations, then presents the product low and high
// words. Every output is a registered decode of the next state, so each output
// is a clean flop that reflects the current state.
//
// Parameters
//   WIDTH  : operand width in bits; must be even and at least 4
//   RADIX4 : 0 = radix-2 recoding on {q0,q_1}, 1 = radix-4 on {q1,q0,q_1}
//
// Ports
//   clk   : clock, rising edge
//   rst_b : asynchronous active-low reset
//   bgn   : start request, sampled only in IDLE
//   q_1   : Booth extra bit below the multiplier LSB
//   q0    : multiplier bit 0
//   q1    : multiplier bit 1 (radix-4 only)
//   c0    : load operands, clear accumulator and q_1
//   c1    : examine recoding bits
//   c2    : accumulator update enable
//   c3    : subtract (1) / add (0) the multiplicand, valid with c2
//   c4    : arithmetic right shift of {A,Q,q_1} (1 or 2 places)
//   c5    : drive product low word
//   c6    : drive product high word
//   c7    : use 2x multiplicand, valid with c2 (radix-4 only)
//   busy  : high in every state except IDLE
//   stop  : one-cycle completion pulse
// -----------------------------------------------------------------------------
module booth_seq_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RADIX4 = 0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic bgn,
  input  logic q_1,
  input  logic q0,
  input  logic q1,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic c7,
  output logic busy,
  output logic stop
);

  localparam int unsigned N_ITER   = (RADIX4 != 0) ? (WIDTH / 2) : WIDTH;
  localparam int unsigned CNT_W    = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  // Reject illegal parameterisations at elaboration time
  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_seq_ctrl: WIDTH must be even and >= 4");
  end
  if (RADIX4 > 1) begin : g_bad_radix
    $error("booth_seq_ctrl: RADIX4 must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EXAM   = 3'd2,
    ADDSUB = 3'd3,
    SHIFT  = 3'd4,
    OUT_LO = 3'd5,
    OUT_HI = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             dbl_q, dbl_d;
  logic             rec_op, rec_sub, rec_dbl;
  logic [7:0]       c_d;
  logic             busy_d, stop_d;

  // Booth recoding of the live multiplier bits; only consumed in EXAM
  always_comb begin
    rec_op  = 1'b0;
    rec_sub = 1'b0;
    rec_dbl = 1'b0;
    if (RADIX4 != 0) begin
      case ({q1, q0, q_1})
        3'b001, 3'b010: rec_op = 1'b1;
        3'b011: begin
          rec_op  = 1'b1;
          rec_dbl = 1'b1;
        end
        3'b100: begin
          rec_op  = 1'b1;
          rec_sub = 1'b1;
          rec_dbl = 1'b1;
        end
        3'b101, 3'b110: begin
          rec_op  = 1'b1;
          rec_sub = 1'b1;
        end
        default: ;
      endcase
    end else begin
      // q1 is a don't-care in radix-2 mode
      casez ({q1, q0, q_1})
        3'b?10: begin
          rec_op  = 1'b1;
          rec_sub = 1'b1;
        end
        3'b?01:  rec_op = 1'b1;
        default: ;
      endcase
    end
  end

  // Next state, counter, recoding flags and next-cycle output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    dbl_d   = dbl_q;
    c_d     = 8'h00;
    busy_d  = 1'b0;
    stop_d  = 1'b0;

    unique case (state_q)
      IDLE:    if (bgn) state_d = LOAD;
      LOAD:    state_d = EXAM;
      EXAM:    state_d = rec_op ? ADDSUB : SHIFT;
      ADDSUB:  state_d = SHIFT;
      SHIFT:   state_d = (cnt_q == CNT_LAST) ? OUT_LO : EXAM;
      OUT_LO:  state_d = OUT_HI;
      OUT_HI:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counter saturates at the last iteration instead of wrapping
    if (state_q == LOAD) begin
      cnt_d = '0;
    end else if ((state_q == SHIFT) && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Freeze the recoding decision so q changes during ADDSUB are harmless
    if (state_q == EXAM) begin
      sub_d = rec_sub;
      dbl_d = rec_dbl;
    end

    c_d[0] = (state_d == LOAD);
    c_d[1] = (state_d == EXAM);
    c_d[2] = (state_d == ADDSUB);
    c_d[3] = (state_d == ADDSUB) && sub_d;
    c_d[4] = (state_d == SHIFT);
    c_d[5] = (state_d == OUT_LO);
    c_d[6] = (state_d == OUT_HI);
    c_d[7] = (state_d == ADDSUB) && dbl_d;
    busy_d = (state_d != IDLE);
    stop_d = (state_d == OUT_HI);
  end

  // State, counter, flags and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      dbl_q   <= 1'b0;
      c0      <= 1'b0;
      c1      <= 1'b0;
      c2      <= 1'b0;
      c3      <= 1'b0;
      c4      <= 1'b0;
      c5      <= 1'b0;
      c6      <= 1'b0;
      c7      <= 1'b0;
      busy    <= 1'b0;
      stop    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      dbl_q   <= dbl_d;
      c0      <= c_d[0];
      c1      <= c_d[1];
      c2      <= c_d[2];
      c3      <= c_d[3];
      c4      <= c_d[4];
      c5      <= c_d[5];
      c6      <= c_d[6];
      c7      <= c_d[7];
      busy    <= busy_d;
      stop    <= stop_d;
    end
  end

  // Structural invariants of the control word
  a_c2_c4_excl: assert property (@(posedge clk) disable iff (!rst_b)
    !(c2 && c4));
  a_c0_alone: assert property (@(posedge clk) disable iff (!rst_b)
    c0 |-> !(c1 || c2 || c3 || c4 || c5 || c6 || c7));
  a_stop_pulse: assert property (@(posedge clk) disable iff (!rst_b)
    stop |=> !stop);

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_ctrl
// Bench for booth_seq_ctrl. Three instances: WIDTH=8 radix-2 (unit a),
// WIDTH=8 radix-4 (unit b), WIDTH=32 radix-4 (unit d, closed around a small
// Booth datapath model to multiply real operands).
// -----------------------------------------------------------------------------
module tb_booth_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;

  logic       bgn_a, q_1a, q0a, q1a, busy_a, stop_a;
  logic [7:0] ca;
  logic       bgn_b, q_1b, q0b, q1b, busy_b, stop_b;
  logic [7:0] cb;
  logic       bgn_d, q_1d, q0d, q1d, busy_d, stop_d;
  logic [7:0] cd;

  booth_seq_ctrl #(.WIDTH(8), .RADIX4(0)) u_a (
    .clk(clk), .rst_b(rst_b), .bgn(bgn_a), .q_1(q_1a), .q0(q0a), .q1(q1a),
    .c0(ca[0]), .c1(ca[1]), .c2(ca[2]), .c3(ca[3]), .c4(ca[4]), .c5(ca[5]),
    .c6(ca[6]), .c7(ca[7]), .busy(busy_a), .stop(stop_a));

  booth_seq_ctrl #(.WIDTH(8), .RADIX4(1)) u_b (
    .clk(clk), .rst_b(rst_b), .bgn(bgn_b), .q_1(q_1b), .q0(q0b), .q1(q1b),
    .c0(cb[0]), .c1(cb[1]), .c2(cb[2]), .c3(cb[3]), .c4(cb[4]), .c5(cb[5]),
    .c6(cb[6]), .c7(cb[7]), .busy(busy_b), .stop(stop_b));

  booth_seq_ctrl #(.WIDTH(32), .RADIX4(1)) u_d (
    .clk(clk), .rst_b(rst_b), .bgn(bgn_d), .q_1(q_1d), .q0(q0d), .q1(q1d),
    .c0(cd[0]), .c1(cd[1]), .c2(cd[2]), .c3(cd[3]), .c4(cd[4]), .c5(cd[5]),
    .c6(cd[6]), .c7(cd[7]), .busy(busy_d), .stop(stop_d));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Radix-4 datapath model for unit d (updates on the falling edge)
  // ---------------------------------------------------------------------------
  logic signed [33:0] dp_a    = '0;
  logic [31:0]        dp_q    = '0;
  logic [31:0]        dp_m    = '0;
  logic               dp_qm   = 1'b0;
  logic [31:0]        mcand_in = '0;
  logic [31:0]        mult_in  = '0;
  logic signed [33:0] dp_add;
  logic signed [66:0] dp_t;

  assign q0d  = dp_q[0];
  assign q1d  = dp_q[1];
  assign q_1d = dp_qm;

  always @(negedge clk) begin
    dp_add = {{2{dp_m[31]}}, dp_m};
    if (cd[7]) dp_add = dp_add <<< 1;
    if (cd[0]) begin
      dp_a  <= '0;
      dp_q  <= mult_in;
      dp_qm <= 1'b0;
      dp_m  <= mcand_in;
    end else if (cd[2]) begin
      dp_a <= cd[3] ? (dp_a - dp_add) : (dp_a + dp_add);
    end else if (cd[4]) begin
      dp_t = {dp_a, dp_q, dp_qm};
      dp_t = dp_t >>> 2;
      {dp_a, dp_q, dp_qm} <= dp_t;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table and scoreboard for the 8-bit units
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         which;    // 0: unit a (radix-2), 1: unit b (radix-4)
    logic [2:0] q_even;   // {q1,q0,q_1} presented on even iterations
    logic [2:0] q_odd;    // {q1,q0,q_1} presented on odd iterations
    int         k;        // expected ADDSUB visits
    logic [1:0] f_even;   // expected {c3,c7} in ADDSUB on even iterations
    logic [1:0] f_odd;    // expected {c3,c7} in ADDSUB on odd iterations
  } vec_t;

  typedef struct {
    int lat;
    int k;
    int shifts;
  } exp_t;

  exp_t sb[$];
  longint prod_q[$];
  vec_t vt[16];

  function automatic vec_t mk(input bit w, input logic [2:0] qe, input logic [2:0] qo,
                              input int k, input logic [1:0] fe, input logic [1:0] fo);
    vec_t v;
    v.which = w; v.q_even = qe; v.q_odd = qo; v.k = k; v.f_even = fe; v.f_odd = fo;
    return v;
  endfunction

  function automatic logic [9:0] outs(input bit w);
    return w ? {stop_b, busy_b, cb} : {stop_a, busy_a, ca};
  endfunction

  task automatic drive(input bit w, input logic bg, input logic [2:0] q);
    if (w) begin
      bgn_b = bg; {q1b, q0b, q_1b} = q;
    end else begin
      bgn_a = bg; {q1a, q0a, q_1a} = q;
    end
  endtask

  // One operation on unit a or b; call at a falling edge with the unit idle
  task automatic run_op(input int idx, input vec_t v);
    exp_t       e, got;
    int         edges, it, nk, nsh, ferr, berr, n;
    logic [9:0] o;
    logic [1:0] fexp;
    logic [2:0] qcur;
    bit         done;
    n        = v.which ? 4 : 8;
    e.lat    = 3 + 2 * n + v.k;
    e.k      = v.k;
    e.shifts = n;
    sb.push_back(e);
    drive(v.which, 1'b1, v.q_even);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    drive(v.which, 1'b0, v.q_even);
    it = 0; nk = 0; nsh = 0; ferr = 0; berr = 0; done = 0;
    qcur = v.q_even;
    while (!done && edges < 200) begin
      o = outs(v.which);
      if (!o[8]) berr++;
      if (o[9]) begin
        done = 1;
      end else begin
        if (o[2]) begin
          nk++;
          fexp = it[0] ? v.f_odd : v.f_even;
          if ({o[3], o[7]} !== fexp) ferr++;
          // Scramble q while in ADDSUB; the latched recoding must not move
          drive(v.which, 1'b0, ~qcur);
        end
        if (o[4]) begin
          nsh++;
          it++;
          qcur = it[0] ? v.q_odd : v.q_even;
          drive(v.which, 1'b0, qcur);
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
    check($sformatf("v%0d_stop_seen", idx), done, 1);
    got = sb.pop_front();
    check($sformatf("v%0d_latency", idx), edges, got.lat);
    check($sformatf("v%0d_addsub_visits", idx), nk, got.k);
    check($sformatf("v%0d_shifts", idx), nsh, got.shifts);
    check($sformatf("v%0d_recode_errs", idx), ferr, 0);
    check($sformatf("v%0d_busy_drops", idx), berr, 0);
    @(posedge clk);
    @(negedge clk);
    o = outs(v.which);
    check($sformatf("v%0d_stop_cleared", idx), o[9], 0);
    check($sformatf("v%0d_idle_after", idx), o[8], 0);
  endtask

  initial begin
    int         edges, last, guard, nsh, bad;
    logic [9:0] o;
    logic [31:0] a, b;
    logic [31:0] lo, hi;
    longint     exp_p;
    bit         done;

    // Radix-2 unit: {q1,q0,q_1}; q1 must be ignored
    vt[0]  = mk(0, 3'b000, 3'b000, 0, 2'b00, 2'b00);
    vt[1]  = mk(0, 3'b010, 3'b001, 8, 2'b10, 2'b00);
    vt[2]  = mk(0, 3'b011, 3'b011, 0, 2'b00, 2'b00);
    vt[3]  = mk(0, 3'b001, 3'b001, 8, 2'b00, 2'b00);
    vt[4]  = mk(0, 3'b110, 3'b110, 8, 2'b10, 2'b10);
    vt[5]  = mk(0, 3'b101, 3'b101, 8, 2'b00, 2'b00);
    // Radix-4 unit: all eight recoding patterns, plus an alternating case
    vt[6]  = mk(1, 3'b000, 3'b000, 0, 2'b00, 2'b00);
    vt[7]  = mk(1, 3'b001, 3'b001, 4, 2'b00, 2'b00);
    vt[8]  = mk(1, 3'b010, 3'b010, 4, 2'b00, 2'b00);
    vt[9]  = mk(1, 3'b011, 3'b011, 4, 2'b01, 2'b01);
    vt[10] = mk(1, 3'b100, 3'b100, 4, 2'b11, 2'b11);
    vt[11] = mk(1, 3'b101, 3'b101, 4, 2'b10, 2'b10);
    vt[12] = mk(1, 3'b110, 3'b110, 4, 2'b10, 2'b10);
    vt[13] = mk(1, 3'b111, 3'b111, 0, 2'b00, 2'b00);
    vt[14] = mk(1, 3'b011, 3'b100, 4, 2'b01, 2'b11);
    vt[15] = mk(0, 3'b000, 3'b000, 0, 2'b00, 2'b00);

    // Reset with bgn asserted: everything must stay quiet
    rst_b = 1'b0;
    drive(0, 1'b1, 3'b000);
    drive(1, 1'b1, 3'b000);
    bgn_d = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outs_a", outs(0), 0);
    check("rst_outs_b", outs(1), 0);
    check("rst_outs_d", {stop_d, busy_d, cd}, 0);
    drive(0, 1'b0, 3'b000);
    drive(1, 1'b0, 3'b000);
    bgn_d = 1'b0;
    rst_b = 1'b1;

    // First op starts at the first edge after reset release
    for (int i = 0; i < 16; i++) run_op(i, vt[i]);

    // Abort during the 5th SHIFT
    drive(0, 1'b1, 3'b000);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 3'b000);
    nsh = 0; guard = 0;
    o = outs(0);
    while (guard < 100) begin
      o = outs(0);
      if (o[4]) nsh++;
      if (nsh == 5) break;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check("abort_in_shift5", o[4] && (nsh == 5), 1);
    #2 rst_b = 1'b0;
    #1 check("abort_outs_zero", outs(0), 0);
    @(negedge clk);
    check("abort_held_zero", outs(0), 0);
    rst_b = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (stop_a || busy_a) bad++;
    end
    check("abort_no_stop", bad, 0);
    run_op(16, vt[1]);

    // bgn held high: back-to-back operations with one IDLE cycle between
    drive(0, 1'b1, 3'b000);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    last = 0;
    for (int op = 0; op < 3; op++) begin
      guard = 0;
      while (!stop_a && guard < 100) begin
        @(posedge clk);
        edges++;
        guard++;
        @(negedge clk);
      end
      if (op == 0) check("b2b_first_stop", edges, 19);
      else check($sformatf("b2b_period%0d", op), edges - last, 20);
      last = edges;
      @(posedge clk); edges++; @(negedge clk);
      check($sformatf("b2b_idle_gap%0d", op), {busy_a, ca[0]}, 2'b00);
      @(posedge clk); edges++; @(negedge clk);
      check($sformatf("b2b_restart%0d", op), {busy_a, ca[0]}, 2'b11);
    end
    drive(0, 1'b0, 3'b000);
    guard = 0;
    while (busy_a && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check("b2b_quiet", {busy_a, stop_a}, 2'b00);

    // 32-bit radix-4 signed products through the datapath model
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0: begin a = 32'h0000_0000; b = 32'h0000_0000; end
        1: begin a = 32'h8000_0000; b = 32'h8000_0000; end
        2: begin a = 32'h8000_0000; b = 32'h7fff_ffff; end
        3: begin a = 32'h7fff_ffff; b = 32'h7fff_ffff; end
        4: begin a = 32'hffff_ffff; b = 32'hffff_ffff; end
        5: begin a = 32'h0000_0001; b = 32'hffff_ffff; end
        6: begin a = 32'haaaa_aaaa; b = 32'h5555_5555; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      mcand_in = a;
      mult_in  = b;
      exp_p = longint'($signed(a)) * longint'($signed(b));
      prod_q.push_back(exp_p);
      bgn_d = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bgn_d = 1'b0;
      lo = 'x; hi = 'x; done = 0; guard = 0;
      while (!done && guard < 200) begin
        if (cd[5]) lo = dp_q;
        if (cd[6]) hi = dp_a[31:0];
        if (stop_d) begin
          done = 1;
        end else begin
          @(posedge clk);
          @(negedge clk);
          guard++;
        end
      end
      exp_p = prod_q.pop_front();
      if (!done) check($sformatf("product%0d_done", i), done, 1);
      check($sformatf("product%0d a=%h b=%h", i, a, b), longint'({hi, lo}), exp_p);
      @(posedge clk);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal values are even and at least 4.
REQ-002 SHALL have parameter RADIX4, default 0: 0 selects radix-2 Booth recoding, 1 selects radix-4 Booth recoding.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_b, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port bgn, input, 1 bit: start request, sampled only in IDLE.
REQ-006 SHALL have port q_1, input, 1 bit: Booth extra bit below the multiplier LSB.
REQ-007 SHALL have port q0, input, 1 bit: multiplier LSB.
REQ-008 SHALL have port q1, input, 1 bit: multiplier bit 1; used only when RADIX4=1.
REQ-009 SHALL have port c0, output, 1 bit: load operands, clear accumulator and q_1.
REQ-010 SHALL have port c1, output, 1 bit: examine recoding bits.
REQ-011 SHALL have port c2, output, 1 bit: accumulator update enable.
REQ-012 SHALL have port c3, output, 1 bit: subtract (1) or add (0) the multiplicand; valid with c2.
REQ-013 SHALL have port c4, output, 1 bit: arithmetic right shift of {A,Q,q_1}; 1 position if RADIX4=0, 2 positions if RADIX4=1.
REQ-014 SHALL have port c5, output, 1 bit: drive the result low word onto the output bus.
REQ-015 SHALL have port c6, output, 1 bit: drive the result high word onto the output bus.
REQ-016 SHALL have port c7, output, 1 bit: select 2xmultiplicand as the addend; valid with c2; always 0 when RADIX4=0.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port stop, output, 1 bit: operation complete; high for exactly one cycle.

Function
REQ-019 SHALL use iteration count N = WIDTH when RADIX4=0, and N = WIDTH/2 when RADIX4=1.
REQ-020 SHALL keep an internal iteration counter of width clog2(N); no external count input.
REQ-021 SHALL implement Moore states IDLE, LOAD, EXAM, ADDSUB, SHIFT, OUT_LO, OUT_HI; every output is a pure decode of state plus registered recoding flags, with no latches and all outputs defined in every state.
REQ-022 SHALL apply these state transitions:
- IDLE->LOAD if bgn=1, else stay in IDLE
- LOAD->EXAM
- EXAM->ADDSUB if an add is required, else EXAM->SHIFT
- ADDSUB->SHIFT
- SHIFT->EXAM if counter != N-1, else SHIFT->OUT_LO
- OUT_LO->OUT_HI
- OUT_HI->IDLE
REQ-023 SHALL assert outputs by state: LOAD gives c0; EXAM gives c1; ADDSUB gives c2, plus c3/c7 per recoding; SHIFT gives c4; OUT_LO gives c5; OUT_HI gives c6 and stop.
REQ-024 SHALL use radix-2 recoding in EXAM, on {q0,q_1}: 10 means subtract; 01 means add; 00 and 11 mean no ADDSUB.
REQ-025 SHALL use radix-4 recoding in EXAM, on {q1,q0,q_1}:
- 000, 111: no ADDSUB
- 001, 010: add M
- 011: add 2M (c7=1)
- 100: subtract 2M (c3=1, c7=1)
- 101, 110: subtract M (c3=1)
REQ-026 SHALL latch the recoding result in EXAM, so that q inputs changing in ADDSUB do not affect c3 or c7.
REQ-027 SHALL clear the counter in LOAD, increment it in SHIFT, and never wrap it within one operation.
REQ-028 SHALL have operation latency, from the edge that samples bgn to the edge entering OUT_HI, of 3 + 2N + K cycles, where K is the number of ADDSUB visits.
REQ-029 SHALL ignore bgn while busy=1; bgn held high through OUT_HI starts a new operation one cycle after returning to IDLE.
REQ-030 SHALL assert c2 and c4 in mutually exclusive cycles, and SHALL never assert c0 together with any other c output.

Reset
REQ-031 SHALL, while rst_b=0, force state IDLE, counter 0, recoding flags 0, and all outputs (c0-c7, busy, stop) to 0, independent of clk.
REQ-032 SHALL abort any operation in progress when rst_b is asserted; stop is not asserted for the aborted operation.
REQ-033 SHALL, after rst_b deasserts, start in IDLE and respond to bgn at the first subsequent rising edge.

Verification
REQ-034 SHALL cover: WIDTH=8, RADIX4=0, q0=q_1=0 throughout, bgn pulsed -> c4 high 8 times, c2 never high, stop high in the cycle after the 19th edge counting from the bgn-sampling edge.
REQ-035 SHALL cover: WIDTH=8, RADIX4=0, {q0,q_1}=10 then 01 alternating -> ADDSUB every iteration with c3 pattern 1,0,1,0,...; stop after 27 edges.
REQ-036 SHALL cover: WIDTH=8, RADIX4=1, each of the 8 values of {q1,q0,q_1} in turn -> c2/c3/c7 exactly per REQ-025, with 4 shifts total.
REQ-037 SHALL cover: rst_b pulsed low mid-SHIFT during iteration 5 -> all outputs 0 immediately, no stop, and a fresh operation after release completes normally.
REQ-038 SHALL cover: bgn held high continuously -> back-to-back operations separated by exactly one IDLE cycle, with bgn ignored while busy.
REQ-039 SHALL cover: WIDTH=32, RADIX4=1, a random multiplier with a datapath model -> product equals the reference multiply for 1000 signed vectors.
